// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: write-port modes, per-channel
// state machine states and the burst counter width.
package led_pattern_pkg;

  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ON,
    ST_BLINK,
    ST_B_WAIT,
    ST_B_RUN
  } ch_state_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode state machine, blink rate select and burst counter.
// Outputs are combinational; the top registers them.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CNT_W  = 33,
  parameter int RATE_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic               pwm_on_i,
  input  logic               wr_i,
  input  mode_e              mode_i,
  input  logic [RATE_W-1:0]  rate_i,
  input  logic [BURST_W-1:0] count_i,
  output logic               led_o,
  output logic               done_o
);

  ch_state_e          state_q, state_d;
  logic [RATE_W-1:0]  rate_q, rate_d, rate_wr;
  logic [BURST_W-1:0] left_q, left_d;
  logic               prev_q, prev_d;
  logic               phase, rise, fall, lit, done;

  assign phase   = cnt_i[rate_q];
  assign rise    = phase & ~prev_q;
  assign fall    = ~phase & prev_q;
  assign rate_wr = (int'(rate_i) >= CNT_W) ? RATE_W'(CNT_W - 1) : rate_i;

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    left_d  = left_q;
    prev_d  = phase;
    lit     = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_OFF:   lit = 1'b0;
      ST_ON:    lit = 1'b1;
      ST_BLINK: lit = phase;
      // The rising edge itself is the first lit cycle of the burst.
      ST_B_WAIT: begin
        lit = rise;
        if (rise) state_d = ST_B_RUN;
      end
      ST_B_RUN: begin
        lit = phase;
        if (fall) begin
          left_d = left_q - BURST_W'(1);
          if (left_q == BURST_W'(1)) begin
            state_d = ST_OFF;
            done    = 1'b1;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    // A write overrides whatever the burst logic decided this cycle.
    if (wr_i) begin
      done   = 1'b0;
      rate_d = rate_wr;
      prev_d = cnt_i[rate_wr];
      unique case (mode_i)
        MODE_OFF:   state_d = ST_OFF;
        MODE_ON:    state_d = ST_ON;
        MODE_BLINK: state_d = ST_BLINK;
        MODE_BURST: begin
          if (count_i != '0) begin
            state_d = ST_B_WAIT;
            left_d  = count_i;
          end else begin
            state_d = ST_OFF;
            done    = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      rate_q  <= '0;
      left_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      left_q  <= left_d;
      prev_q  <= prev_d;
    end
  end

  assign led_o  = lit & pwm_on_i;
  assign done_o = done;

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-channel LED driver: free-running counter, global PWM duty, write
// decode and registered LED / burst_done outputs around per-channel engines.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter  int CHANNELS = 8,
  parameter  int CNT_W    = 33,
  parameter  int PWM_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int RATE_W   = $clog2(CNT_W)
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic [BURST_W-1:0]  cfg_count,
  input  logic                duty_wr,
  input  logic [PWM_W-1:0]    duty,
  output logic [CHANNELS-1:0] LEDG,
  output logic [CHANNELS-1:0] burst_done
);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic [CHANNELS-1:0] led_q, done_q;
  logic [CHANNELS-1:0] wr_en, led_d, done_d;
  logic                pwm_on;

  assign cnt_d  = cnt_q + CNT_W'(1);
  assign duty_d = duty_wr ? duty : duty_q;
  // All-ones duty bypasses the compare so full brightness has no dark slot.
  assign pwm_on = (&duty_q) | (cnt_q[PWM_W-1:0] < duty_q);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_en[i] = cfg_wr && (cfg_ch == CH_W'(i));

    led_channel #(
      .CNT_W  (CNT_W),
      .RATE_W (RATE_W)
    ) u_ch (
      .clk_i    (CLOCK_50),
      .rst_i    (RESET),
      .cnt_i    (cnt_q),
      .pwm_on_i (pwm_on),
      .wr_i     (wr_en[i]),
      .mode_i   (mode_e'(cfg_mode)),
      .rate_i   (cfg_rate),
      .count_i  (cfg_count),
      .led_o    (led_d[i]),
      .done_o   (done_d[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_q  <= '0;
      duty_q <= '1;
      led_q  <= '0;
      done_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign LEDG       = led_q;
  assign burst_done = done_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench: stimulus queues expected LEDG/burst_done per cycle,
// a negedge monitor pops and compares.
module tb_led_pattern_engine;

  localparam int CH = 6;

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic          cfg_wr;
  logic [2:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [2:0]    cfg_rate;
  logic [3:0]    cfg_count;
  logic          duty_wr;
  logic [1:0]    duty;
  logic [CH-1:0] LEDG;
  logic [CH-1:0] burst_done;

  led_pattern_engine #(.CHANNELS(CH), .CNT_W(8), .PWM_W(2)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_rate   (cfg_rate),
    .cfg_count  (cfg_count),
    .duty_wr    (duty_wr),
    .duty       (duty),
    .LEDG       (LEDG),
    .burst_done (burst_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         at;
    logic [5:0] lm, lv, dm, dv;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tcnt  = 0;   // expected DUT counter value after the latest edge

  always @(posedge CLOCK_50) begin
    cyc  <= cyc + 1;
    tcnt <= RESET ? 0 : ((tcnt + 1) % 256);
  end

  // Monitor: at the negedge of cycle m, LEDG reflects the counter value tcnt-1.
  always @(negedge CLOCK_50) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.at != cyc || (LEDG & e.lm) !== e.lv || (burst_done & e.dm) !== e.dv) begin
        bad++;
        $display("FAIL %s cyc=%0d(at %0d) LEDG=%b need %b mask %b, done=%b need %b mask %b",
                 e.tag, cyc, e.at, LEDG, e.lv, e.lm, burst_done, e.dv, e.dm);
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input int at, input logic [5:0] lm, input logic [5:0] lv,
                      input logic [5:0] dm, input logic [5:0] dv, input string tag);
    exp_t x;
    x.at = at; x.lm = lm; x.lv = lv; x.dm = dm; x.dv = dv; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic wr(input int ch, input int mode, input int rate, input int count);
    cfg_ch    = 3'(ch);
    cfg_mode  = 2'(mode);
    cfg_rate  = 3'(rate);
    cfg_count = 4'(count);
    cfg_wr    = 1'b1;
    step();
    cfg_wr    = 1'b0;
  endtask

  task automatic wait_mod(input int m, input int v);
    int n = 0;
    while ((tcnt % m) != v && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_cnt tcnt=%0d need %0d mod %0d", tcnt, v, m);
    end
  endtask

  initial begin
    int c0, t0, src, r;
    RESET = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_rate = '0;
    cfg_count = '0; duty_wr = 1'b0; duty = '0;
    repeat (3) step();
    RESET = 1'b0;

    // 1: reset state and idle, then ch0 ON
    c0 = cyc;
    for (int k = 0; k < 20; k++) push(c0 + k, 6'h3F, 6'h00, 6'h3F, 6'h00, "idle");
    repeat (20) step();
    c0 = cyc;
    push(c0,     6'h01, 6'h00, 6'h3F, 6'h00, "on_pre");
    push(c0 + 1, 6'h01, 6'h00, 6'h3F, 6'h00, "on_lat");
    for (int k = 2; k < 10; k++) push(c0 + k, 6'h01, 6'h01, 6'h3F, 6'h00, "on");
    wr(0, 1, 0, 0);
    repeat (8) step();

    // 2: ch1 BLINK rate 3
    c0 = cyc; t0 = tcnt;
    push(c0 + 1, 6'h02, 6'h00, 6'h3F, 6'h00, "blink_lat");
    for (int m = c0 + 2; m < c0 + 42; m++) begin
      src = (t0 + m - c0 - 1) % 256;
      push(m, 6'h03, 6'(((src >> 3) & 1) * 2 + 1), 6'h3F, 6'h00, "blink");
    end
    wr(1, 2, 3, 0);
    repeat (41) step();

    // 3: ch2 BURST rate 3 count 2 written at cnt 2
    wait_mod(256, 2);
    c0 = cyc;
    for (int m = c0 + 1; m < c0 + 63; m++) begin
      src = m - c0 + 1;
      push(m, 6'h04, ((src >= 8 && src <= 15) || (src >= 24 && src <= 31)) ? 6'h04 : 6'h00,
           6'h3F, (src == 32) ? 6'h04 : 6'h00, "burst");
    end
    wr(2, 3, 3, 2);
    repeat (62) step();

    // 4: duty 1 then duty 3 on ch0
    c0 = cyc; t0 = tcnt;
    for (int m = c0 + 2; m < c0 + 18; m++) begin
      src = (t0 + m - c0 - 1) % 256;
      push(m, 6'h01, (src % 4 == 0) ? 6'h01 : 6'h00, 6'h3F, 6'h00, "duty1");
    end
    duty = 2'd1; duty_wr = 1'b1; step(); duty_wr = 1'b0;
    repeat (16) step();
    c0 = cyc;
    for (int m = c0 + 2; m < c0 + 10; m++) push(m, 6'h01, 6'h01, 6'h3F, 6'h00, "duty3");
    duty = 2'd3; duty_wr = 1'b1; step(); duty_wr = 1'b0;
    repeat (8) step();

    // 5a: ch3 burst aborted by OFF write while running
    wait_mod(4, 0);
    c0 = cyc;
    push(c0 + 1, 6'h08, 6'h00, 6'h3F, 6'h00, "abort_wait");
    push(c0 + 2, 6'h08, 6'h00, 6'h3F, 6'h00, "abort_wait");
    push(c0 + 3, 6'h08, 6'h08, 6'h3F, 6'h00, "abort_run");
    push(c0 + 4, 6'h08, 6'h08, 6'h3F, 6'h00, "abort_run");
    for (int m = c0 + 5; m < c0 + 21; m++) push(m, 6'h08, 6'h00, 6'h3F, 6'h00, "abort_off");
    wr(3, 3, 1, 3);
    step(); step();
    wr(3, 0, 0, 0);
    repeat (17) step();

    // 5b: BURST count 0 completes immediately
    c0 = cyc;
    push(c0 + 1, 6'h10, 6'h00, 6'h3F, 6'h10, "cnt0_done");
    for (int m = c0 + 2; m < c0 + 7; m++) push(m, 6'h10, 6'h00, 6'h3F, 6'h00, "cnt0_after");
    wr(4, 3, 2, 0);
    repeat (5) step();

    // 5c: out-of-range channel writes change nothing
    c0 = cyc;
    for (int m = c0 + 1; m < c0 + 9; m++) push(m, 6'h3D, 6'h01, 6'h3F, 6'h00, "bad_ch");
    wr(6, 1, 0, 0);
    wr(7, 2, 1, 0);
    repeat (6) step();

    // 6: reset mid-burst together with cfg_wr and duty_wr
    wait_mod(8, 0);
    c0 = cyc;
    push(c0 + 5, 6'h04, 6'h04, 6'h3F, 6'h00, "rst_pre");
    push(c0 + 6, 6'h04, 6'h04, 6'h3F, 6'h00, "rst_pre");
    wr(2, 3, 2, 3);
    repeat (5) step();
    r = cyc + 1;
    push(r, 6'h3F, 6'h00, 6'h3F, 6'h00, "rst_state");
    RESET = 1'b1; duty = 2'd1; duty_wr = 1'b1;
    cfg_ch = 3'd5; cfg_mode = 2'd1; cfg_rate = 3'd0; cfg_count = 4'd0; cfg_wr = 1'b1;
    step();
    RESET = 1'b0; duty_wr = 1'b0; cfg_wr = 1'b0;
    push(r + 1, 6'h3F, 6'h00, 6'h3F, 6'h00, "rst_after");
    for (int m = r + 2; m < r + 26; m++) begin
      src = m - r - 1;
      push(m, 6'h3F, 6'(((src >> 1) & 1) * 2), 6'h3F, 6'h00, "rst_blink");
    end
    wr(1, 2, 1, 0);
    repeat (26) step();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
